// File: rtl/serial_byte_receiver_if.sv
// rtl/serial_byte_receiver_if.sv - serial input and parallel output signal bundle for serial_byte_receiver
interface serial_byte_receiver_if #(
    parameter int DATA_W = 8
);
    logic              i_serial;
    logic              i_valid;
    logic              i_sync;
    logic              i_ready;
    logic              i_clr_ovr;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_overrun;
    logic              o_busy;

    modport slave (
        input  i_serial,
        input  i_valid,
        input  i_sync,
        input  i_ready,
        input  i_clr_ovr,
        output o_data,
        output o_valid,
        output o_overrun,
        output o_busy
    );

    modport master (
        output i_serial,
        output i_valid,
        output i_sync,
        output i_ready,
        output i_clr_ovr,
        input  o_data,
        input  o_valid,
        input  o_overrun,
        input  o_busy
    );
endinterface

// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - MSB-first serial-to-parallel word receiver with holding register and sticky overrun
module serial_byte_receiver #(
    parameter int DATA_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    serial_byte_receiver_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] o_data_r;
    logic              o_valid_r;
    logic              o_overrun_r;
    logic              o_busy_r;

    // The shift register with the current bit appended, used by both partial and completing strobes.
    logic [DATA_W-1:0] shreg_next;
    assign shreg_next = {shreg[DATA_W-2:0], bus.i_serial};

    // Word assembly, holding register handoff and overrun tracking, all registered.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            o_data_r    <= '0;
            o_valid_r   <= 1'b0;
            o_overrun_r <= 1'b0;
            o_busy_r    <= 1'b0;
        end else begin
            // A consumed word frees the holding register; a completion below may refill it on the same edge.
            if (o_valid_r && bus.i_ready) begin
                o_valid_r <= 1'b0;
            end
            // Clear comes first so a same-edge overrun set overrides it.
            if (bus.i_clr_ovr) begin
                o_overrun_r <= 1'b0;
            end
            if (bus.i_valid) begin
                if (bus.i_sync) begin
                    // Frame start realigns from any state; a partial word is silently abandoned.
                    shreg    <= {{(DATA_W-1){1'b0}}, bus.i_serial};
                    cnt      <= CNT_W'(1);
                    state    <= SHIFT;
                    o_busy_r <= 1'b1;
                end else if (state == SHIFT) begin
                    shreg <= shreg_next;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        // Last bit of the word: wrap the counter so the stream continues without resync.
                        cnt <= '0;
                        if (!o_valid_r || bus.i_ready) begin
                            o_data_r  <= shreg_next;
                            o_valid_r <= 1'b1;
                        end else begin
                            o_overrun_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.o_data    = o_data_r;
    assign bus.o_valid   = o_valid_r;
    assign bus.o_overrun = o_overrun_r;
    assign bus.o_busy    = o_busy_r;
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb/tb_serial_byte_receiver.sv - self-checking bench for serial_byte_receiver
module tb_serial_byte_receiver;
    localparam int DATA_W = 8;

    logic i_clk;
    logic i_rstn;
    logic run;
    int   checks;
    int   errors;

    serial_byte_receiver_if #(.DATA_W(DATA_W)) bus ();

    serial_byte_receiver #(.DATA_W(DATA_W)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: alignment flag, bit count and arithmetic word value.
    logic        m_aligned;
    int          m_nbits;
    int          m_word;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ovr;
    logic [7:0]  mdl_log[$];
    logic [7:0]  dut_log[$];

    always @(posedge i_clk) begin
        if (!i_rstn) begin
            m_aligned = 1'b0;
            m_nbits   = 0;
            m_word    = 0;
            m_data    = 8'h00;
            m_valid   = 1'b0;
            m_ovr     = 1'b0;
        end else begin
            if (m_valid && bus.i_ready) begin
                mdl_log.push_back(m_data);
                m_valid = 1'b0;
            end
            if (bus.i_clr_ovr) m_ovr = 1'b0;
            if (bus.i_valid) begin
                if (bus.i_sync) begin
                    m_aligned = 1'b1;
                    m_nbits   = 1;
                    m_word    = int'(bus.i_serial);
                end else if (m_aligned) begin
                    m_word  = m_word * 2 + int'(bus.i_serial);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == DATA_W) begin
                        if (!m_valid) begin
                            m_data  = m_word[7:0];
                            m_valid = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                        m_nbits = 0;
                        m_word  = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, plus DUT-side acceptance log.
    always @(negedge i_clk) begin
        if (run) begin
            checks++;
            if (bus.o_valid !== m_valid) begin
                errors++;
                $display("FAIL cyc_valid t=%0t got %b want %b", $time, bus.o_valid, m_valid);
            end
            checks++;
            if (bus.o_data !== m_data) begin
                errors++;
                $display("FAIL cyc_data t=%0t got %h want %h", $time, bus.o_data, m_data);
            end
            checks++;
            if (bus.o_overrun !== m_ovr) begin
                errors++;
                $display("FAIL cyc_overrun t=%0t got %b want %b", $time, bus.o_overrun, m_ovr);
            end
            checks++;
            if (bus.o_busy !== m_aligned) begin
                errors++;
                $display("FAIL cyc_busy t=%0t got %b want %b", $time, bus.o_busy, m_aligned);
            end
            if (i_rstn && bus.o_valid && bus.i_ready) dut_log.push_back(bus.o_data);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic check_logs(input string nm, input int n, input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] w[2];
        w[0] = w0;
        w[1] = w1;
        check({nm, "_dut_n"}, dut_log.size(), n);
        check({nm, "_mdl_n"}, mdl_log.size(), n);
        for (int i = 0; i < n && i < 2; i++) begin
            if (i < dut_log.size()) check({nm, "_dut_w"}, dut_log[i], w[i]);
            if (i < mdl_log.size()) check({nm, "_mdl_w"}, mdl_log[i], w[i]);
        end
    endtask

    task automatic clear_logs();
        dut_log.delete();
        mdl_log.delete();
    endtask

    task automatic send_bit(input logic b, input logic s);
        bus.i_valid  = 1'b1;
        bus.i_serial = b;
        bus.i_sync   = s;
        @(posedge i_clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_sync   = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] v, input logic do_sync, input logic gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps && i != 7) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge i_clk);
                    #1;
                end
            end
            send_bit(v[i], do_sync && (i == 7));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        run    = 1'b0;
        i_rstn = 1'b0;
        bus.i_serial  = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_sync    = 1'b0;
        bus.i_ready   = 1'b0;
        bus.i_clr_ovr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        run = 1'b1;
        @(negedge i_clk);
        check("rst_data", bus.o_data, 0);
        check("rst_valid", bus.o_valid, 0);
        check("rst_overrun", bus.o_overrun, 0);
        check("rst_busy", bus.o_busy, 0);

        // Unsynced strobes in IDLE are ignored.
        @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_serial = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        check("idle_busy", bus.o_busy, 0);
        check("idle_valid", bus.o_valid, 0);

        // Single word 8'hA5, one-cycle valid pulse.
        clear_logs();
        bus.i_ready = 1'b1;
        send_word(8'hA5, 1'b1, 1'b0);
        @(negedge i_clk);
        check("single_valid", bus.o_valid, 1);
        check("single_data", bus.o_data, 8'hA5);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("single_drop", bus.o_valid, 0);
        check_logs("single", 1, 8'hA5, 8'h00);

        // Back-to-back words without resync, with idle gaps.
        clear_logs();
        send_word(8'h3C, 1'b0, 1'b1);
        send_word(8'hF0, 1'b0, 1'b1);
        repeat (2) @(posedge i_clk);
        #1;
        check_logs("b2b", 2, 8'h3C, 8'hF0);
        check("b2b_ovr", bus.o_overrun, 0);

        // Backpressure: second word dropped, overrun set.
        clear_logs();
        bus.i_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0);
        @(negedge i_clk);
        check("bp_data", bus.o_data, 8'h11);
        check("bp_ovr", bus.o_overrun, 1);
        check("bp_valid", bus.o_valid, 1);
        bus.i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_ready = 1'b0;
        @(negedge i_clk);
        check("bp_consumed", bus.o_valid, 0);
        check("bp_data_hold", bus.o_data, 8'h11);
        bus.i_clr_ovr = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_clr_ovr = 1'b0;
        @(negedge i_clk);
        check("bp_clr", bus.o_overrun, 0);
        check_logs("bp", 1, 8'h11, 8'h00);

        // Completion and consumption on the same edge.
        clear_logs();
        send_word(8'h55, 1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hAA >> i), 1'b0);
        bus.i_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        @(negedge i_clk);
        check("sim_data", bus.o_data, 8'hAA);
        check("sim_valid", bus.o_valid, 1);
        check("sim_ovr", bus.o_overrun, 0);
        @(posedge i_clk);
        #1;
        check_logs("sim", 2, 8'h55, 8'hAA);

        // Resync mid-word discards the partial bits.
        clear_logs();
        for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
        send_word(8'hC3, 1'b1, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check_logs("resync", 1, 8'hC3, 8'h00);

        // Reset mid-word, then unsynced strobes must produce nothing.
        clear_logs();
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        i_rstn = 1'b0;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check("mrst_data", bus.o_data, 0);
        check("mrst_valid", bus.o_valid, 0);
        check("mrst_ovr", bus.o_overrun, 0);
        check("mrst_busy", bus.o_busy, 0);
        i_rstn = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
        @(negedge i_clk);
        check("mrst_idle_busy", bus.o_busy, 0);
        check_logs("mrst", 0, 8'h00, 8'h00);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Serial-to-parallel receiver that assembles an MSB-first, bit-strobed serial stream into DATA_W-bit words and presents them on a valid/ready output port. It is the receive-side counterpart of the team's parallel-load, MSB-first shift-out register. It sits between a serial link input and a parallel consumer. A frame-sync input aligns word boundaries. A one-word output holding register decouples the consumer. A sticky overrun flag reports words lost to backpressure.

## Interface
- DATA_W, 8, word width in bits (≥2)
- i_clk  input  1  clock; all state changes on rising edge
- i_rstn  input  1  reset: synchronous, active-low; clock i_clk
- i_serial  input  1  serial data bit, MSB first
- i_valid  input  1  bit strobe; i_serial is sampled only on edges where i_valid=1
- i_sync  input  1  frame start; meaningful only with i_valid=1; marks the sampled bit as the MSB of a new word
- i_ready  input  1  consumer accepts o_data on edges where o_valid=1 and i_ready=1
- i_clr_ovr  input  1  clears o_overrun
- o_data  output  DATA_W  received word, stable while o_valid=1
- o_valid  output  1  o_data holds an unconsumed word
- o_overrun  output  1  sticky: at least one completed word was dropped
- o_busy  output  1  state is SHIFT (word assembly in progress or aligned)

## Operation
- Reset (i_rstn=0 at an edge) forces the following, with priority over all other inputs:
  - state IDLE, shift register 0, bit counter 0
  - o_data=0, o_valid=0, o_overrun=0, o_busy=0
- States:
  - IDLE: serial bits are ignored. On i_valid & i_sync, the bit is loaded as the MSB, the counter becomes 1, and the state moves to SHIFT.
  - SHIFT: on i_valid, shreg <= {shreg[DATA_W-2:0], i_serial} and the counter increments.
    - On i_valid & i_sync in SHIFT, the partial word is discarded and the sampled bit becomes bit 1 of the new word (counter=1). No error is flagged.
    - Word completion: the edge that samples bit number DATA_W. The counter wraps to 0 and the state stays SHIFT, so the next strobed bit starts the next word (back-to-back stream, no re-sync required).
- Completion handling, evaluated at the completing edge:
  - Holding register free, or being consumed on this same edge (o_valid=0, or o_valid & i_ready): o_data <= the completed word and o_valid <= 1.
  - Holding register full and not consumed (o_valid & !i_ready): the completed word is dropped, o_data stays unchanged, and o_overrun <= 1.
- Consumption without completion: o_valid & i_ready clears o_valid; o_data holds its last value.
- o_overrun is cleared by i_clr_ovr. If a set and a clear occur on the same edge, set wins.
- o_busy = (state == SHIFT).

## Timing
- Bit sampling is registered: each i_valid edge consumes exactly one bit, and i_valid may be high every cycle.
- Latency: o_valid is high in the cycle immediately after the edge that sampled the last bit (1 cycle).
- Full-rate throughput: one word per DATA_W strobed bits with zero bubbles, provided i_ready is high on the completion edge.
- If completion and consumption fall on the same edge, the new word replaces the consumed one and o_valid stays 1 without dropping.
- Mid-word idle: gaps with i_valid=0 pause assembly indefinitely and the counter holds.
- Reset mid-word, or with o_valid=1, discards everything. Bits must be re-aligned with i_sync after reset.
- o_data, o_valid and o_overrun change only at rising edges; there are no combinational input-to-output paths.

## Test plan
- **Reset values:** after reset, all outputs are 0.
  - Stimulus: with i_rstn=1, i_valid=1 and i_sync=0 for 20 cycles.
  - Response: o_busy=0 and o_valid=0 throughout (IDLE ignores unsynced bits).
- **Single word:** i_sync with the first bit, serial 1,0,1,0,0,1,0,1 on 8 consecutive strobes, i_ready=1.
  - Response: o_valid=1 for exactly one cycle, the cycle after the 8th bit, with o_data=8'hA5.
- **Back-to-back with gaps:** stream 8'h3C then 8'hF0 with no second sync and random i_valid gaps, i_ready=1.
  - Response: two outputs, 8'h3C then 8'hF0; o_overrun=0.
- **Backpressure and overrun:** i_ready=0 while words 8'h11 then 8'h22 are received.
  - Response: o_data remains 8'h11 and o_overrun=1 at the 2nd completion.
  - Then i_ready=1 for one cycle: 8'h11 is accepted and o_valid drops.
  - Then i_clr_ovr=1: o_overrun=0.
- **Simultaneous complete and consume:** hold o_valid=1 with 8'h55, then raise i_ready on the same edge that completes 8'hAA.
  - Response: o_data=8'hAA, o_valid stays 1, o_overrun=0.
- **Resync and reset mid-word:**
  - Resync: 4 bits of one word, then i_sync with bits of 8'hC3. Response: output 8'hC3 only.
  - Reset mid-word: assert i_rstn=0 after 5 bits. Response: all outputs 0, o_busy=0, and no word is emitted from the partial bits.
